// File: rtl/bram_cam_lookup_if.sv
// AXI4-Lite slave bundle for the bram_cam_lookup table-update port.
// 32-bit data and address. The slave modport is the CAM side.
interface bram_cam_lookup_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/bram_cam_lookup.sv
// Hashed exact-match CAM: one BRAM slot per hash, three-cycle lookup pipeline, AXI4-Lite table writes.
// Define CAM_AXI_READBACK_EN to build the port-A read path; otherwise AXI reads return zero.
module bram_cam_lookup #(
  parameter int CAM_DEPTH = 2048,
  parameter int TUPLE_W   = 244
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic [TUPLE_W-1:0] tuple,
  output logic               valid,
  output logic               match,
  output logic [15:0]        action,
  bram_cam_lookup_if.slave   s_axi
);

  localparam int IW     = $clog2(CAM_DEPTH);
  localparam int NCH    = (TUPLE_W + IW - 1) / IW;
  localparam int NWORDS = 9;

  typedef logic [IW-1:0] slot_t;

  // XOR-fold of IW-bit chunks from bit 0 upward; last chunk zero-padded.
  function automatic slot_t hash_slot(input logic [TUPLE_W-1:0] t);
    logic [NCH*IW-1:0] padded;
    slot_t             h;
    padded              = '0;
    padded[TUPLE_W-1:0] = t;
    h                   = '0;
    for (int i = 0; i < NCH; i++) h ^= padded[i*IW +: IW];
    return h;
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic               active_q, active_d;
  logic               bvalid_q, bvalid_d;
  logic               wr_hs;
  slot_t              wr_slot;
  logic [3:0]         wr_word;
  slot_t              porta_slot;

  logic               lk_valid0_q, lk_valid0_d;
  logic [TUPLE_W-1:0] key0_q, key0_d;
  slot_t              slot0_q, slot0_d;
  logic               lk_valid1_q, lk_valid1_d;
  logic [TUPLE_W-1:0] key1_q, key1_d;
  logic               valid_q, valid_d;
  logic               match_q, match_d;
  logic [15:0]        action_q, action_d;

  logic [NWORDS-1:0][31:0] rd_b;
  logic [255:0]            stored_all;
  logic                    hit;

  assign wr_slot = s_axi.awaddr[IW+5:6];
  assign wr_word = s_axi.awaddr[5:2];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    active_d = 1'b1;
    wr_hs    = active_q & s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
    bvalid_d = wr_hs | (bvalid_q & ~s_axi.bready);
  end

  assign s_axi.awready = wr_hs;
  assign s_axi.wready  = wr_hs;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;

  // ---------------------------------------------------------------------------
  // AXI read channel
  // ---------------------------------------------------------------------------
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ar_hs;

`ifdef CAM_AXI_READBACK_EN
  logic                    rd_pend_q, rd_pend_d;
  logic [3:0]              rd_word_q, rd_word_d;
  slot_t                   rd_slot;
  logic [NWORDS-1:0][31:0] rd_a;

  assign rd_slot = s_axi.araddr[IW+5:6];
  // Port A carries one access per cycle, so a write handshake defers a read.
  assign porta_slot    = wr_hs ? wr_slot : rd_slot;
  assign s_axi.arready = active_q & ~rd_pend_q & ~rvalid_q & ~wr_hs;

  always_comb begin
    ar_hs     = s_axi.arready & s_axi.arvalid;
    rd_pend_d = ar_hs;
    rd_word_d = ar_hs ? s_axi.araddr[5:2] : rd_word_q;
    rvalid_d  = rd_pend_q | (rvalid_q & ~s_axi.rready);
    rdata_d   = rdata_q;
    if (rd_pend_q) begin
      if (rd_word_q < 4'd8)       rdata_d = rd_a[rd_word_q];
      else if (rd_word_q == 4'd8) rdata_d = rd_a[8] & 32'h8000_FFFF;
      else                        rdata_d = '0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_pend_q <= 1'b0;
      rd_word_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_word_q <= rd_word_d;
    end
  end
`else
  assign porta_slot    = wr_slot;
  assign s_axi.arready = active_q & ~rvalid_q;

  always_comb begin
    ar_hs    = s_axi.arready & s_axi.arvalid;
    rvalid_d = ar_hs | (rvalid_q & ~s_axi.rready);
    rdata_d  = '0;
  end
`endif

  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = 2'b00;

  // ---------------------------------------------------------------------------
  // Table storage: one 32-bit true-dual-port slice per word (A = AXI, B = lookup)
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NWORDS; k++) begin : g_slice
    logic [31:0] mem [CAM_DEPTH];
    logic [31:0] q_b;

    // NOTE: table contents are not reset; only control state is, which keeps this a plain BRAM.
    always_ff @(posedge s_axi_aclk) begin
      if (wr_hs && (wr_word == 4'(k))) begin
        for (int b = 0; b < 4; b++) begin
          if (s_axi.wstrb[b]) mem[porta_slot][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
      q_b <= mem[slot0_q];
    end
    assign rd_b[k] = q_b;

`ifdef CAM_AXI_READBACK_EN
    logic [31:0] q_a;
    always_ff @(posedge s_axi_aclk) q_a <= mem[porta_slot];
    assign rd_a[k] = q_a;
`endif
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline: C0 register+hash, C1 BRAM read, C2 compare
  // ---------------------------------------------------------------------------
  assign stored_all = rd_b[7:0];

  always_comb begin
    lk_valid0_d = tuple[TUPLE_W-1];
    key0_d      = tuple;
    slot0_d     = hash_slot(tuple);
    lk_valid1_d = lk_valid0_q;
    key1_d      = key0_q;
    hit         = lk_valid1_q & rd_b[8][31] & (stored_all[TUPLE_W-1:0] == key1_q);
    valid_d     = lk_valid1_q;
    match_d     = hit;
    action_d    = hit ? rd_b[8][15:0] : 16'h0000;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      active_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      lk_valid0_q <= 1'b0;
      key0_q      <= '0;
      slot0_q     <= '0;
      lk_valid1_q <= 1'b0;
      key1_q      <= '0;
      valid_q     <= 1'b0;
      match_q     <= 1'b0;
      action_q    <= '0;
    end else begin
      active_q    <= active_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      lk_valid0_q <= lk_valid0_d;
      key0_q      <= key0_d;
      slot0_q     <= slot0_d;
      lk_valid1_q <= lk_valid1_d;
      key1_q      <= key1_d;
      valid_q     <= valid_d;
      match_q     <= match_d;
      action_q    <= action_d;
    end
  end

  assign valid  = valid_q;
  assign match  = match_q;
  assign action = action_q;

  // Address high bits, prot and the non-compared stored bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr,
                         stored_all, rd_b[8]};

endmodule

// File: tb/tb_bram_cam_lookup.sv
// Directed bench for bram_cam_lookup: AXI table writes, lookup hits/misses, latency,
// byte strobes, read-first collision and reset behaviour.
module tb_bram_cam_lookup;
  localparam int CAM_DEPTH = 2048;
  localparam int TUPLE_W   = 244;
  localparam int IW        = 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [TUPLE_W-1:0] tuple;
  logic               valid;
  logic               match;
  logic [15:0]        action;

  bram_cam_lookup_if s_axi ();

  bram_cam_lookup #(.CAM_DEPTH(CAM_DEPTH), .TUPLE_W(TUPLE_W)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .tuple        (tuple),
    .valid        (valid),
    .match        (match),
    .action       (action),
    .s_axi        (s_axi)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bitwise form of the chunk-XOR fold: bit i lands in slot bit i mod IW.
  function automatic logic [IW-1:0] model_hash(input logic [TUPLE_W-1:0] t);
    logic [IW-1:0] h;
    h = '0;
    for (int i = 0; i < TUPLE_W; i++) h[i % IW] ^= t[i];
    return h;
  endfunction

  function automatic logic [31:0] addr_of(input logic [IW-1:0] slot, input int word);
    return (32'(slot) << 6) | (32'(word) << 2);
  endfunction

  function automatic logic [TUPLE_W-1:0] make_tuple(
    input logic [15:0] port, input logic [47:0] dmac, input logic [47:0] smac,
    input logic [15:0] typ, input logic [31:0] sip, input logic [31:0] dip,
    input logic [15:0] tsp, input logic [15:0] tdp);
    logic [TUPLE_W-1:0] t;
    t            = '0;
    t[15:0]      = tdp;
    t[31:16]     = tsp;
    t[63:32]     = dip;
    t[95:64]     = sip;
    t[111:96]    = typ;
    t[159:112]   = smac;
    t[207:160]   = dmac;
    t[223:208]   = port;
    t[TUPLE_W-1] = 1'b1;
    return t;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    s_axi.awaddr  = addr;
    s_axi.wdata   = data;
    s_axi.wstrb   = strb;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    #1;
    check("wr_awready", s_axi.awready, 1'b1);
    check("wr_wready", s_axi.wready, 1'b1);
    tick();
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    #1;
    check("wr_awready_drop", s_axi.awready, 1'b0);
    check("wr_bvalid", s_axi.bvalid, 1'b1);
    check("wr_bresp", s_axi.bresp, 2'b00);
    tick();
    check("wr_bvalid_hold", s_axi.bvalid, 1'b1);
    s_axi.bready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
    check("wr_bvalid_clr", s_axi.bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp);
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    #1;
    check("rd_arready", s_axi.arready, 1'b1);
    tick();
    s_axi.arvalid = 1'b0;
`ifdef CAM_AXI_READBACK_EN
    check("rd_rvalid_early", s_axi.rvalid, 1'b0);
    check("rd_arready_busy", s_axi.arready, 1'b0);
    tick();
    check("rd_rvalid", s_axi.rvalid, 1'b1);
    check("rd_rdata", s_axi.rdata, exp);
`else
    check("rd_rvalid", s_axi.rvalid, 1'b1);
    check("rd_rdata_zero", s_axi.rdata, 32'h0);
`endif
    check("rd_rresp", s_axi.rresp, 2'b00);
    tick();
    check("rd_rvalid_hold", s_axi.rvalid, 1'b1);
    s_axi.rready = 1'b1;
    tick();
    s_axi.rready = 1'b0;
    check("rd_rvalid_clr", s_axi.rvalid, 1'b0);
  endtask

  task automatic write_entry(input logic [TUPLE_W-1:0] t, input logic [15:0] act);
    logic [255:0]  tp;
    logic [IW-1:0] slot;
    tp   = 256'(t);
    slot = model_hash(t);
    for (int k = 0; k < 8; k++) axi_write(addr_of(slot, k), tp[32*k +: 32], 4'hF);
    axi_write(addr_of(slot, 8), {16'h8000, act}, 4'hF);
  endtask

  task automatic lookup(input string tag, input logic [TUPLE_W-1:0] t,
                        input logic exp_match, input logic [15:0] exp_action);
    tuple = t;
    tick();
    tuple = '0;
    check({tag, "_lat1"}, valid, 1'b0);
    tick();
    check({tag, "_lat2"}, valid, 1'b0);
    tick();
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_match"}, match, exp_match);
    check({tag, "_action"}, action, exp_action);
  endtask

  logic [TUPLE_W-1:0] t_hit, t_miss;
  logic [IW-1:0]      hit_slot;
  logic [255:0]       hit_pad;

  initial begin
    t_hit    = make_tuple(16'd2, 48'h0025_90d1_849c, 48'h0025_90d1_849d, 16'd8,
                          32'hC0A8_CC03, 32'hC0A8_CC05, 16'd2134, 16'd80);
    t_miss   = make_tuple(16'd2, 48'h0025_90d1_849c, 48'h0025_90d1_849d, 16'd8,
                          32'hC0A8_CC03, 32'hC0A8_CC05, 16'd2134, 16'd81);
    hit_slot = model_hash(t_hit);
    hit_pad  = 256'(t_hit);

    tuple         = '0;
    s_axi.awaddr  = '0;
    s_axi.awprot  = '0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.bready  = 1'b0;
    s_axi.araddr  = '0;
    s_axi.arprot  = '0;
    s_axi.rready  = 1'b0;
    // Requests held high during reset must not be accepted.
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    s_axi.arvalid = 1'b1;

    #12;
    check("rst_valid", valid, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_action", action, 16'h0);
    check("rst_bvalid", s_axi.bvalid, 1'b0);
    check("rst_rvalid", s_axi.rvalid, 1'b0);
    check("rst_awready", s_axi.awready, 1'b0);
    check("rst_wready", s_axi.wready, 1'b0);
    check("rst_arready", s_axi.arready, 1'b0);
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    s_axi.arvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // AW alone is held off until W joins; target word 12 (write ignored).
    s_axi.awaddr  = addr_of(hit_slot, 12);
    s_axi.wdata   = 32'hFFFF_FFFF;
    s_axi.wstrb   = 4'hF;
    s_axi.awvalid = 1'b1;
    #1;
    check("holdoff_awready", s_axi.awready, 1'b0);
    check("holdoff_wready", s_axi.wready, 1'b0);
    tick();
    check("holdoff_awready2", s_axi.awready, 1'b0);
    check("holdoff_bvalid", s_axi.bvalid, 1'b0);
    s_axi.wvalid = 1'b1;
    #1;
    check("joined_awready", s_axi.awready, 1'b1);
    tick();
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    check("joined_bvalid", s_axi.bvalid, 1'b1);
    s_axi.bready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
    check("joined_bvalid_clr", s_axi.bvalid, 1'b0);

    // Program the flow entry and look it up.
    write_entry(t_hit, 16'hABCD);
    lookup("hit", t_hit, 1'b1, 16'hABCD);
    lookup("miss_tdp81", t_miss, 1'b0, 16'h0000);

    // Byte strobe: only the low action byte changes.
    axi_write(addr_of(hit_slot, 8), 32'h0000_00EE, 4'b0001);
    lookup("strb_hit", t_hit, 1'b1, 16'hABEE);
    axi_write(addr_of(hit_slot, 8), 32'h8000_ABCD, 4'hF);

    axi_read(addr_of(hit_slot, 8), 32'h8000_ABCD);
    axi_read(addr_of(hit_slot, 0), hit_pad[31:0]);
    axi_read(addr_of(hit_slot, 12), 32'h0000_0000);

    // Back-to-back hit, miss, hit on consecutive cycles.
    tuple = t_hit;
    tick();
    tuple = t_miss;
    tick();
    tuple = t_hit;
    tick();
    tuple = '0;
    check("b2b_0_valid", valid, 1'b1);
    check("b2b_0_match", match, 1'b1);
    check("b2b_0_action", action, 16'hABCD);
    tick();
    check("b2b_1_valid", valid, 1'b1);
    check("b2b_1_match", match, 1'b0);
    check("b2b_1_action", action, 16'h0000);
    tick();
    check("b2b_2_valid", valid, 1'b1);
    check("b2b_2_match", match, 1'b1);
    check("b2b_2_action", action, 16'hABCD);
    tick();
    check("b2b_idle", valid, 1'b0);

    // All-zero tuple issues no lookup.
    tuple = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero_no_valid", valid, 1'b0);
    end

    // Read-first: lookup 1's BRAM read coincides with the write clearing word 8.
    tuple = t_hit;
    tick();
    tuple         = t_hit;
    s_axi.awaddr  = addr_of(hit_slot, 8);
    s_axi.wdata   = 32'h0000_0000;
    s_axi.wstrb   = 4'hF;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    #1;
    check("coll_awready", s_axi.awready, 1'b1);
    tick();
    tuple         = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    check("coll_bvalid", s_axi.bvalid, 1'b1);
    tick();
    check("coll_old_valid", valid, 1'b1);
    check("coll_old_match", match, 1'b1);
    check("coll_old_action", action, 16'hABCD);
    tick();
    check("coll_new_valid", valid, 1'b1);
    check("coll_new_match", match, 1'b0);
    check("coll_new_action", action, 16'h0000);
    s_axi.bready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
    check("coll_bvalid_clr", s_axi.bvalid, 1'b0);

    lookup("cleared", t_hit, 1'b0, 16'h0000);

    // Reset while a B response is pending: bvalid drops at once, table is kept.
    s_axi.awaddr  = addr_of(hit_slot, 8);
    s_axi.wdata   = 32'h8000_ABCD;
    s_axi.wstrb   = 4'hF;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    #1;
    check("rstb_awready", s_axi.awready, 1'b1);
    tick();
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    #1;
    check("rstb_bvalid", s_axi.bvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstb_bvalid_drop", s_axi.bvalid, 1'b0);
    check("rstb_arready", s_axi.arready, 1'b0);
    check("rstb_valid", valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rstb_no_bvalid", s_axi.bvalid, 1'b0);
    tick();
    lookup("after_rst", t_hit, 1'b1, 16'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
